// File: rtl/usb_gpx_event_ctrl_if.sv
// Avalon-MM slave bus bundle for the GPX event controller.
// The CPU side drives the master modport; the controller takes the slave modport.
interface usb_gpx_event_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/usb_gpx_event_ctrl.sv
// MAX3421E GPX pin controller: synchroniser, glitch filter, edge capture, irq, event counter.
// Optional feature macro USB_GPX_EVCOUNT_EN builds the event counter at address 3.
module usb_gpx_event_ctrl #(
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    usb_gpx_event_ctrl_if.slave  bus,
    input  logic                 in_port,
    output logic                 irq
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FILTER_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          flt_q,     flt_d;
    logic          flt_dly_q;
    logic [FW-1:0] fcnt_q,    fcnt_d;
    logic [2:0]    ctrl_q,    ctrl_d;
    logic          cap_q,     cap_d;
    logic          irq_q,     irq_d;
    logic [31:0]   rdata_q,   rdata_d;

    logic          wr_s;
    logic          rise_s;
    logic          fall_s;
    logic          ev_s;
    logic [31:0]   cnt_rd_s;
    logic          unused_wdata_s;

    assign wr_s           = bus.chipselect & ~bus.write_n;
    assign rise_s         = flt_q & ~flt_dly_q;
    assign fall_s         = ~flt_q & flt_dly_q;
    assign unused_wdata_s = ^bus.writedata[31:3];

    // Filtered level only moves after FILTER_CYCLES consecutive disagreeing samples.
    always_comb begin
        flt_d  = flt_q;
        fcnt_d = {FW{1'b0}};
        if (s2_q != flt_q) begin
            if (fcnt_q == FCNT_LAST) begin
                flt_d  = s2_q;
                fcnt_d = {FW{1'b0}};
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end else begin
            fcnt_d = {FW{1'b0}};
        end
    end

    always_comb begin
        case (ctrl_q[2:1])
            2'b01:   ev_s = rise_s;
            2'b10:   ev_s = fall_s;
            2'b11:   ev_s = rise_s | fall_s;
            default: ev_s = 1'b0;
        endcase
    end

    // A new event outranks a software clear arriving in the same cycle.
    always_comb begin
        ctrl_d = ctrl_q;
        cap_d  = cap_q;
        if (wr_s && (bus.address == 2'd1)) begin
            ctrl_d = bus.writedata[2:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (ev_s) begin
            cap_d = 1'b1;
        end else if (wr_s && (bus.address == 2'd2) && bus.writedata[0]) begin
            cap_d = 1'b0;
        end else begin
            cap_d = cap_q;
        end
        irq_d = cap_q & ctrl_q[0];
    end

`ifdef USB_GPX_EVCOUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_s && (bus.address == 2'd3)) begin
            cnt_d = ev_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (ev_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_rd_s = 32'(cnt_q);
`else
    assign cnt_rd_s = 32'd0;
`endif

    always_comb begin
        case (bus.address)
            2'd0:    rdata_d = {31'd0, flt_q};
            2'd1:    rdata_d = {29'd0, ctrl_q};
            2'd2:    rdata_d = {31'd0, cap_q};
            2'd3:    rdata_d = cnt_rd_s;
            default: rdata_d = 32'd0;
        endcase
    end

    // Pin path: two synchroniser stages, filter state and a one-cycle delayed copy for edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            flt_q     <= 1'b0;
            flt_dly_q <= 1'b0;
            fcnt_q    <= {FW{1'b0}};
        end else begin
            s1_q      <= in_port;
            s2_q      <= s1_q;
            flt_q     <= flt_d;
            flt_dly_q <= flt_q;
            fcnt_q    <= fcnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= 3'd0;
            cap_q   <= 1'b0;
            irq_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            cap_q   <= cap_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule
